fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Control state machine that sequences the 8-bit program counter for the lab CPU's fetch stage. It starts execution on a `start` pulse, then advances the PC each cycle. It redirects the PC on jumps and taken branches, holds it on stalls, and stops on a decoded halt. It sits between the decoder/branch-compare logic and the instruction ROM address input, and owns `pc`, the fetch enable and the run status.

## Interface
- `PC_W`, 8: PC width; all address arithmetic is modulo 2^PC_W.
- `START_ADDR`, 0: PC value loaded on reset and on every start.
- `CNT_W`, 16: width of the retired-fetch counter.

- `clock`  in  1  single clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `start`  in  1  single-cycle pulse that begins execution from `START_ADDR`; honoured only in IDLE or HALT.
- `stall`  in  1  hold the PC this cycle; same-cycle control inputs are ignored.
- `halt_req`  in  1  current instruction is HALT.
- `jump_ctrl`  in  1  current instruction is an absolute jump.
- `jump_target`  in  PC_W  absolute jump address.
- `branch_ctrl`  in  1  current instruction is a conditional branch.
- `branch_taken`  in  1  branch condition result; qualifies `branch_ctrl`.
- `branch_offset`  in  PC_W  two's-complement offset, applied as PC + offset.
- `pc`  out  PC_W  registered ROM address.
- `fetch_en`  out  1  ROM read enable; 1 when `pc` holds a valid fetch.
- `redirect`  out  1  registered one-cycle pulse: `pc` was loaded by a jump or a taken branch.
- `busy`  out  1  1 in RUN.
- `done`  out  1  1 in HALT.
- `fetch_count`  out  CNT_W  number of PC advances since the last start; saturating.

## Operation
- The states are IDLE, RUN and HALT. On reset the block enters IDLE.
- IDLE:
  - `pc`=START_ADDR, `fetch_en`=0, `busy`=0, `done`=0, `redirect`=0, `fetch_count`=0.
  - `start` moves to RUN; `pc` stays START_ADDR; `fetch_en` goes to 1.
- RUN: each cycle, the first matching rule applies:
  1. `stall`=1: hold `pc` and `fetch_count`. All other control inputs are ignored.
  2. `halt_req`=1: go to HALT, hold `pc`, `fetch_en`=0.
  3. `jump_ctrl`=1: `pc` <= `jump_target`, `redirect`=1.
  4. `branch_ctrl`=1 and `branch_taken`=1: `pc` <= `pc` + `branch_offset` (mod 2^PC_W), `redirect`=1.
  5. Otherwise: `pc` <= `pc` + 1 (mod 2^PC_W). 0xFF wraps to 0x00 and there is no error flag.
- `branch_ctrl`=1 with `branch_taken`=0 follows rule 5. `branch_taken` alone has no effect.
- `fetch_count` increments by 1 on every rule 3-5 cycle and saturates at 2^CNT_W-1.
- HALT:
  - `done`=1, `busy`=0, `fetch_en`=0; `pc` and `fetch_count` are frozen for readout.
  - `start` returns to RUN: `pc`=START_ADDR, `fetch_count`=0, `done`=0.
- `start` in RUN is ignored.
- `reset` overrides everything in any state. On the next edge the block is in IDLE with all outputs at their IDLE values, including mid-stall and mid-redirect.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Decisions use inputs sampled at edge N; the result is visible after edge N.
- Redirect latency is 1 cycle: the target address is on `pc` the cycle after the jump or branch is sampled.
- `redirect` is high for exactly that one cycle and is 0 after any non-redirect cycle.
- After a `start` pulse at edge N, `busy`=1 and `fetch_en`=1 from N+1, with `pc`=START_ADDR.
- The first advance happens at edge N+2 if there is no stall.
- Halt latency is 1 cycle: `done` rises the cycle after `halt_req` is sampled, and `pc` still shows the HALT instruction address.

## Test plan
- **Reset and start.** Assert reset for 2 cycles, pulse start, run 5 cycles with no controls.
  - Required: pc 0,0,1,2,3,4; fetch_en=1 from the cycle after start; fetch_count=4.
- **Jump and taken branch.**
  - At pc=3, jump_ctrl with jump_target=0x40 -> pc=0x40 and redirect=1 for one cycle.
  - Then branch_ctrl=1, branch_taken=1, branch_offset=0xFE -> pc=0x3E.
  - Then branch_ctrl=1, branch_taken=0 -> pc=0x3F.
- **Wrap-around and negative offset.**
  - At pc=0xFF with no control -> pc=0x00.
  - At pc=0x02, taken branch with offset 0xFC -> pc=0xFE.
- **Priority.**
  - stall, halt_req and jump_ctrl all high at pc=0x10 -> pc stays 0x10, state stays RUN.
  - Next cycle halt_req and jump_ctrl high -> HALT, done=1, pc=0x10.
  - Then pulse start -> pc=START_ADDR, fetch_count=0, busy=1.
- **Reset mid-operation.** Assert reset in the same cycle as a taken branch at pc=0x20.
  - Required next cycle: IDLE, pc=0, redirect=0, fetch_en=0, fetch_count=0.
  - start pulses during RUN have no effect.
- **Counter saturation.** With CNT_W=4, run 20 advances -> fetch_count holds 15.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage PC sequencer: IDLE/RUN/HALT control, PC redirect on jump or taken
// branch, stall hold, and a saturating count of PC advances.
module fetch_sequencer #(
    parameter int unsigned    PC_W       = 8,
    parameter logic [PC_W-1:0] START_ADDR = '0,
    parameter int unsigned    CNT_W      = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stall,
    input  logic             halt_req,
    input  logic             jump_ctrl,
    input  logic [PC_W-1:0]  jump_target,
    input  logic             branch_ctrl,
    input  logic             branch_taken,
    input  logic [PC_W-1:0]  branch_offset,
    output logic [PC_W-1:0]  pc,
    output logic             fetch_en,
    output logic             redirect,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [PC_W-1:0]  pc_nxt;
    logic [CNT_W-1:0] count_nxt;
    logic             redirect_nxt;
    logic             fetch_en_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    // State and every output are registered; reset wins over all inputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= START_ADDR;
            fetch_count <= '0;
            redirect    <= 1'b0;
            fetch_en    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            fetch_count <= count_nxt;
            redirect    <= redirect_nxt;
            fetch_en    <= fetch_en_nxt;
            busy        <= busy_nxt;
            done        <= done_nxt;
        end
    end

    // Next state and next register values; in RUN the first matching rule wins.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        count_nxt    = fetch_count;
        redirect_nxt = 1'b0;

        unique case (state)
            IDLE, HALT: begin
                if (start) begin
                    state_nxt = RUN;
                    pc_nxt    = START_ADDR;
                    count_nxt = '0;
                end
            end
            RUN: begin
                if (stall) begin
                    state_nxt = RUN;
                end else if (halt_req) begin
                    state_nxt = HALT;
                end else begin
                    if (jump_ctrl) begin
                        pc_nxt       = jump_target;
                        redirect_nxt = 1'b1;
                    end else if (branch_ctrl && branch_taken) begin
                        pc_nxt       = pc + branch_offset;
                        redirect_nxt = 1'b1;
                    end else begin
                        pc_nxt = pc + PC_W'(1);
                    end
                    if (fetch_count != CNT_MAX) begin
                        count_nxt = fetch_count + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                pc_nxt    = START_ADDR;
                count_nxt = '0;
            end
        endcase

        fetch_en_nxt = (state_nxt == RUN);
        busy_nxt     = (state_nxt == RUN);
        done_nxt     = (state_nxt == HALT);
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: reset/start, redirects, wrap, priority,
// reset during a branch, and counter saturation on a narrow-counter instance.
module tb_fetch_sequencer;

    logic        clock = 1'b0;
    logic        reset, start, stall, halt_req;
    logic        jump_ctrl, branch_ctrl, branch_taken;
    logic [7:0]  jump_target, branch_offset;
    logic [7:0]  pc, pc_s;
    logic        fetch_en, redirect, busy, done;
    logic        fetch_en_s, redirect_s, busy_s, done_s;
    logic [15:0] fetch_count;
    logic [3:0]  fetch_count_s;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    fetch_sequencer dut (
        .clock(clock), .reset(reset), .start(start), .stall(stall),
        .halt_req(halt_req), .jump_ctrl(jump_ctrl), .jump_target(jump_target),
        .branch_ctrl(branch_ctrl), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .pc(pc), .fetch_en(fetch_en),
        .redirect(redirect), .busy(busy), .done(done), .fetch_count(fetch_count)
    );

    fetch_sequencer #(.CNT_W(4)) dut_sat (
        .clock(clock), .reset(reset), .start(start), .stall(stall),
        .halt_req(halt_req), .jump_ctrl(jump_ctrl), .jump_target(jump_target),
        .branch_ctrl(branch_ctrl), .branch_taken(branch_taken),
        .branch_offset(branch_offset), .pc(pc_s), .fetch_en(fetch_en_s),
        .redirect(redirect_s), .busy(busy_s), .done(done_s), .fetch_count(fetch_count_s)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_ctrl();
        start = 0; stall = 0; halt_req = 0; jump_ctrl = 0;
        branch_ctrl = 0; branch_taken = 0; jump_target = 8'h00; branch_offset = 8'h00;
    endtask

    task automatic test_reset();
        clear_ctrl();
        reset = 1;
        step();
        step();
        reset = 0;
        n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL reset_pc: got %h want 00", pc); end
        n_cmp++; if ({fetch_en, busy, done, redirect} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b want 0000", {fetch_en, busy, done, redirect}); end
        n_cmp++; if (fetch_count !== 16'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", fetch_count); end
        step();
        n_cmp++; if ({fetch_en, busy} !== 2'b00) begin n_err++; $display("FAIL idle_no_start: got %b want 00", {fetch_en, busy}); end
    endtask

    task automatic test_start();
        start = 1;
        step();
        start = 0;
        n_cmp++; if (pc !== 8'h00) begin n_err++; $display("FAIL start_pc: got %h want 00", pc); end
        n_cmp++; if ({fetch_en, busy, done} !== 3'b110) begin
            n_err++; $display("FAIL start_flags: got %b want 110", {fetch_en, busy, done}); end
        for (int i = 1; i <= 4; i++) begin
            step();
            n_cmp++; if (pc !== 8'(i)) begin n_err++; $display("FAIL run_pc%0d: got %h want %h", i, pc, 8'(i)); end
        end
        n_cmp++; if (fetch_count !== 16'd4) begin n_err++; $display("FAIL run_count: got %0d want 4", fetch_count); end
    endtask

    task automatic test_jump_branch();
        jump_ctrl = 1; jump_target = 8'h40;
        step();
        clear_ctrl();
        n_cmp++; if ({pc, redirect} !== {8'h40, 1'b1}) begin
            n_err++; $display("FAIL jump: got pc=%h redir=%b want pc=40 redir=1", pc, redirect); end
        branch_ctrl = 1; branch_taken = 1; branch_offset = 8'hFE;
        step();
        clear_ctrl();
        n_cmp++; if ({pc, redirect} !== {8'h3E, 1'b1}) begin
            n_err++; $display("FAIL branch_taken: got pc=%h redir=%b want pc=3e redir=1", pc, redirect); end
        branch_ctrl = 1; branch_taken = 0; branch_offset = 8'h10;
        step();
        clear_ctrl();
        n_cmp++; if ({pc, redirect} !== {8'h3F, 1'b0}) begin
            n_err++; $display("FAIL branch_not_taken: got pc=%h redir=%b want pc=3f redir=0", pc, redirect); end
        branch_taken = 1; branch_offset = 8'h10;
        step();
        clear_ctrl();
        n_cmp++; if ({pc, redirect} !== {8'h40, 1'b0}) begin
            n_err++; $display("FAIL taken_alone: got pc=%h redir=%b want pc=40 redir=0", pc, redirect); end
        n_cmp++; if (fetch_count !== 16'd8) begin n_err++; $display("FAIL jb_count: got %0d want 8", fetch_count); end
    endtask

    task automatic test_wrap();
        jump_ctrl = 1; jump_target = 8'hFF;
        step();
        clear_ctrl();
        step();
        n_cmp++; if ({pc, redirect} !== {8'h00, 1'b0}) begin
            n_err++; $display("FAIL wrap: got pc=%h redir=%b want pc=00 redir=0", pc, redirect); end
        jump_ctrl = 1; jump_target = 8'h02;
        step();
        clear_ctrl();
        branch_ctrl = 1; branch_taken = 1; branch_offset = 8'hFC;
        step();
        clear_ctrl();
        n_cmp++; if (pc !== 8'hFE) begin n_err++; $display("FAIL neg_offset: got %h want fe", pc); end
        n_cmp++; if (fetch_count !== 16'd12) begin n_err++; $display("FAIL wrap_count: got %0d want 12", fetch_count); end
    endtask

    task automatic test_priority();
        jump_ctrl = 1; jump_target = 8'h10;
        step();
        clear_ctrl();
        stall = 1; halt_req = 1; jump_ctrl = 1; jump_target = 8'h55;
        step();
        clear_ctrl();
        n_cmp++; if ({pc, busy, done, redirect} !== {8'h10, 3'b100}) begin
            n_err++; $display("FAIL stall_prio: got pc=%h bdr=%b want pc=10 bdr=100", pc, {busy, done, redirect}); end
        n_cmp++; if (fetch_count !== 16'd13) begin n_err++; $display("FAIL stall_count: got %0d want 13", fetch_count); end
        halt_req = 1; jump_ctrl = 1; jump_target = 8'h55;
        step();
        clear_ctrl();
        n_cmp++; if ({pc, busy, done, fetch_en, redirect} !== {8'h10, 4'b0100}) begin
            n_err++; $display("FAIL halt: got pc=%h bdfr=%b want pc=10 bdfr=0100", pc, {busy, done, fetch_en, redirect}); end
        jump_ctrl = 1; jump_target = 8'h77;
        step();
        step();
        clear_ctrl();
        n_cmp++; if ({pc, done, fetch_count} !== {8'h10, 1'b1, 16'd13}) begin
            n_err++; $display("FAIL halt_frozen: got pc=%h done=%b cnt=%0d want pc=10 done=1 cnt=13", pc, done, fetch_count); end
        start = 1;
        step();
        clear_ctrl();
        n_cmp++; if ({pc, busy, done, fetch_en, fetch_count} !== {8'h00, 3'b101, 16'd0}) begin
            n_err++; $display("FAIL restart: got pc=%h bdf=%b cnt=%0d want pc=00 bdf=101 cnt=0", pc, {busy, done, fetch_en}, fetch_count); end
    endtask

    task automatic test_start_in_run();
        step();
        start = 1;
        step();
        clear_ctrl();
        n_cmp++; if ({pc, busy, fetch_count} !== {8'h02, 1'b1, 16'd2}) begin
            n_err++; $display("FAIL start_in_run: got pc=%h busy=%b cnt=%0d want pc=02 busy=1 cnt=2", pc, busy, fetch_count); end
    endtask

    task automatic test_reset_mid();
        jump_ctrl = 1; jump_target = 8'h20;
        step();
        clear_ctrl();
        branch_ctrl = 1; branch_taken = 1; branch_offset = 8'h05; reset = 1;
        step();
        clear_ctrl();
        reset = 0;
        n_cmp++; if ({pc, redirect, fetch_en, busy, done, fetch_count} !== {8'h00, 4'b0000, 16'd0}) begin
            n_err++; $display("FAIL reset_mid: got pc=%h rfbd=%b cnt=%0d want pc=00 rfbd=0000 cnt=0",
                              pc, {redirect, fetch_en, busy, done}, fetch_count); end
        stall = 1; start = 1;
        step();
        clear_ctrl();
        stall = 1; reset = 1;
        step();
        clear_ctrl();
        reset = 0;
        n_cmp++; if ({busy, fetch_en, pc} !== {2'b00, 8'h00}) begin
            n_err++; $display("FAIL reset_stall: got bf=%b pc=%h want bf=00 pc=00", {busy, fetch_en}, pc); end
    endtask

    task automatic test_saturation();
        start = 1;
        step();
        clear_ctrl();
        for (int i = 0; i < 20; i++) step();
        n_cmp++; if (fetch_count_s !== 4'd15) begin n_err++; $display("FAIL sat_count: got %0d want 15", fetch_count_s); end
        n_cmp++; if (fetch_count !== 16'd20) begin n_err++; $display("FAIL wide_count: got %0d want 20", fetch_count); end
        n_cmp++; if (pc_s !== 8'd20) begin n_err++; $display("FAIL sat_pc: got %h want 14", pc_s); end
    endtask

    initial begin
        test_reset();
        test_start();
        test_jump_branch();
        test_wrap();
        test_priority();
        test_start_in_run();
        test_reset_mid();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
